// File: rtl/decode_issue_queue.sv
// FIFO of decoded instruction records between the decoders and dispatch.
// Define DECODE_ISSUE_QUEUE_HWM_EN to add the highWater_o occupancy peak output.
module decode_issue_queue #(
    parameter int addressWidth            = 64,
    parameter int opcodeSize              = 12,
    parameter int funcUnitCodeSize        = 3,
    parameter int instructionCounterWidth = 64,
    parameter int instMinIdWidth          = 7,
    parameter int PidSize                 = 20,
    parameter int TidSize                 = 16,
    parameter int regAccessPatternSize    = 2,
    parameter int bodySize                = 26,
    parameter int queueDepth              = 8,
    parameter int stallMargin             = 2
) (
    input  logic                               clock_i,
    input  logic                               reset_i,
    input  logic                               enable_i,
    input  logic [opcodeSize-1:0]              opcode_i,
    input  logic [addressWidth-1:0]            instructionAddress_i,
    input  logic [funcUnitCodeSize-1:0]        functionalUnitType_i,
    input  logic [instructionCounterWidth-1:0] instMajId_i,
    input  logic [instMinIdWidth-1:0]          instMinId_i,
    input  logic                               is64Bit_i,
    input  logic [PidSize-1:0]                 instPid_i,
    input  logic [TidSize-1:0]                 instTid_i,
    input  logic [regAccessPatternSize-1:0]    op1rw_i,
    input  logic [regAccessPatternSize-1:0]    op2rw_i,
    input  logic                               op1isReg_i,
    input  logic                               op2isReg_i,
    input  logic                               immIsExtended_i,
    input  logic                               immIsShifted_i,
    input  logic [bodySize-1:0]                instructionBody_i,
    input  logic                               stall_i,
    output logic                               stall_o,
    output logic                               enable_o,
    output logic [opcodeSize-1:0]              opcode_o,
    output logic [addressWidth-1:0]            instructionAddress_o,
    output logic [funcUnitCodeSize-1:0]        functionalUnitType_o,
    output logic [instructionCounterWidth-1:0] instMajId_o,
    output logic [instMinIdWidth-1:0]          instMinId_o,
    output logic                               is64Bit_o,
    output logic [PidSize-1:0]                 instPid_o,
    output logic [TidSize-1:0]                 instTid_o,
    output logic [regAccessPatternSize-1:0]    op1rw_o,
    output logic [regAccessPatternSize-1:0]    op2rw_o,
    output logic                               op1isReg_o,
    output logic                               op2isReg_o,
    output logic                               immIsExtended_o,
    output logic                               immIsShifted_o,
    output logic [bodySize-1:0]                instructionBody_o,
    output logic [$clog2(queueDepth):0]        count_o,
    output logic                               overflow_o
`ifdef DECODE_ISSUE_QUEUE_HWM_EN
    ,
    output logic [$clog2(queueDepth):0]        highWater_o
`endif
);

    localparam int PW = $clog2(queueDepth);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] countOne   = CW'(1);
    localparam logic [CW-1:0] fullLevel  = CW'(queueDepth);
    localparam logic [CW-1:0] stallLevel = CW'(queueDepth - stallMargin);
    localparam logic [PW-1:0] ptrOne     = PW'(1);

    typedef struct packed {
        logic [opcodeSize-1:0]              opcode;
        logic [addressWidth-1:0]            instructionAddress;
        logic [funcUnitCodeSize-1:0]        functionalUnitType;
        logic [instructionCounterWidth-1:0] instMajId;
        logic [instMinIdWidth-1:0]          instMinId;
        logic                               is64Bit;
        logic [PidSize-1:0]                 instPid;
        logic [TidSize-1:0]                 instTid;
        logic [regAccessPatternSize-1:0]    op1rw;
        logic [regAccessPatternSize-1:0]    op2rw;
        logic                               op1isReg;
        logic                               op2isReg;
        logic                               immIsExtended;
        logic                               immIsShifted;
        logic [bodySize-1:0]                instructionBody;
    } record_t;

    record_t          mem [queueDepth];
    record_t          inRec;
    record_t          outRec;
    logic [PW-1:0]    wrPtr;
    logic [PW-1:0]    rdPtr;
    logic [CW-1:0]    count;
    logic [CW-1:0]    countNext;
    logic             isFull;
    logic             doPop;
    logic             doPush;
    logic             dropPush;

    assign inRec = '{
        opcode:             opcode_i,
        instructionAddress: instructionAddress_i,
        functionalUnitType: functionalUnitType_i,
        instMajId:          instMajId_i,
        instMinId:          instMinId_i,
        is64Bit:            is64Bit_i,
        instPid:            instPid_i,
        instTid:            instTid_i,
        op1rw:              op1rw_i,
        op2rw:              op2rw_i,
        op1isReg:           op1isReg_i,
        op2isReg:           op2isReg_i,
        immIsExtended:      immIsExtended_i,
        immIsShifted:       immIsShifted_i,
        instructionBody:    instructionBody_i
    };

    // A pop in the same cycle frees the slot a full-queue push needs.
    assign isFull   = (count == fullLevel);
    assign doPop    = !stall_i && (count != '0);
    assign doPush   = enable_i && (!isFull || doPop);
    assign dropPush = enable_i && isFull && !doPop;

    always_comb begin
        countNext = count;
        if (doPush && !doPop) begin
            countNext = count + countOne;
        end else if (doPop && !doPush) begin
            countNext = count - countOne;
        end
    end

    always_ff @(posedge clock_i) begin
        if (doPush) begin
            mem[wrPtr] <= inRec;
        end
    end

    always_ff @(posedge clock_i) begin
        if (!reset_i) begin
            wrPtr      <= '0;
            rdPtr      <= '0;
            count      <= '0;
            enable_o   <= 1'b0;
            overflow_o <= 1'b0;
            outRec     <= '0;
        end else begin
            count    <= countNext;
            enable_o <= doPop;
            if (doPush) begin
                wrPtr <= wrPtr + ptrOne;
            end
            if (doPop) begin
                rdPtr  <= rdPtr + ptrOne;
                outRec <= mem[rdPtr];
            end
            if (dropPush) begin
                overflow_o <= 1'b1;
            end
        end
    end

`ifdef DECODE_ISSUE_QUEUE_HWM_EN
    always_ff @(posedge clock_i) begin
        if (!reset_i) begin
            highWater_o <= '0;
        end else if (countNext > highWater_o) begin
            highWater_o <= countNext;
        end
    end
`endif

    assign stall_o              = (count >= stallLevel);
    assign count_o              = count;
    assign opcode_o             = outRec.opcode;
    assign instructionAddress_o = outRec.instructionAddress;
    assign functionalUnitType_o = outRec.functionalUnitType;
    assign instMajId_o          = outRec.instMajId;
    assign instMinId_o          = outRec.instMinId;
    assign is64Bit_o            = outRec.is64Bit;
    assign instPid_o            = outRec.instPid;
    assign instTid_o            = outRec.instTid;
    assign op1rw_o              = outRec.op1rw;
    assign op2rw_o              = outRec.op2rw;
    assign op1isReg_o           = outRec.op1isReg;
    assign op2isReg_o           = outRec.op2isReg;
    assign immIsExtended_o      = outRec.immIsExtended;
    assign immIsShifted_o       = outRec.immIsShifted;
    assign instructionBody_o    = outRec.instructionBody;

endmodule

// File: tb/tb_decode_issue_queue.sv
// Directed self-checking bench for decode_issue_queue.
// Covers reset, pass-through, fill/stall, overflow, full push+pop and wrap.
module tb_decode_issue_queue;

    logic        clock_i = 1'b0;
    logic        reset_i = 1'b0;
    logic        enable_i = 1'b0;
    logic [11:0] opcode_i = '0;
    logic [63:0] instructionAddress_i = '0;
    logic [2:0]  functionalUnitType_i = '0;
    logic [63:0] instMajId_i = '0;
    logic [6:0]  instMinId_i = '0;
    logic        is64Bit_i = 1'b0;
    logic [19:0] instPid_i = '0;
    logic [15:0] instTid_i = '0;
    logic [1:0]  op1rw_i = '0;
    logic [1:0]  op2rw_i = '0;
    logic        op1isReg_i = 1'b0;
    logic        op2isReg_i = 1'b0;
    logic        immIsExtended_i = 1'b0;
    logic        immIsShifted_i = 1'b0;
    logic [25:0] instructionBody_i = '0;
    logic        stall_i = 1'b1;

    logic        stall_o;
    logic        enable_o;
    logic [11:0] opcode_o;
    logic [63:0] instructionAddress_o;
    logic [2:0]  functionalUnitType_o;
    logic [63:0] instMajId_o;
    logic [6:0]  instMinId_o;
    logic        is64Bit_o;
    logic [19:0] instPid_o;
    logic [15:0] instTid_o;
    logic [1:0]  op1rw_o;
    logic [1:0]  op2rw_o;
    logic        op1isReg_o;
    logic        op2isReg_o;
    logic        immIsExtended_o;
    logic        immIsShifted_o;
    logic [25:0] instructionBody_o;
    logic [3:0]  count_o;
    logic        overflow_o;
`ifdef DECODE_ISSUE_QUEUE_HWM_EN
    logic [3:0]  highWater_o;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clock_i = ~clock_i;

    decode_issue_queue dut (
        .clock_i(clock_i),
        .reset_i(reset_i),
        .enable_i(enable_i),
        .opcode_i(opcode_i),
        .instructionAddress_i(instructionAddress_i),
        .functionalUnitType_i(functionalUnitType_i),
        .instMajId_i(instMajId_i),
        .instMinId_i(instMinId_i),
        .is64Bit_i(is64Bit_i),
        .instPid_i(instPid_i),
        .instTid_i(instTid_i),
        .op1rw_i(op1rw_i),
        .op2rw_i(op2rw_i),
        .op1isReg_i(op1isReg_i),
        .op2isReg_i(op2isReg_i),
        .immIsExtended_i(immIsExtended_i),
        .immIsShifted_i(immIsShifted_i),
        .instructionBody_i(instructionBody_i),
        .stall_i(stall_i),
        .stall_o(stall_o),
        .enable_o(enable_o),
        .opcode_o(opcode_o),
        .instructionAddress_o(instructionAddress_o),
        .functionalUnitType_o(functionalUnitType_o),
        .instMajId_o(instMajId_o),
        .instMinId_o(instMinId_o),
        .is64Bit_o(is64Bit_o),
        .instPid_o(instPid_o),
        .instTid_o(instTid_o),
        .op1rw_o(op1rw_o),
        .op2rw_o(op2rw_o),
        .op1isReg_o(op1isReg_o),
        .op2isReg_o(op2isReg_o),
        .immIsExtended_o(immIsExtended_o),
        .immIsShifted_o(immIsShifted_o),
        .instructionBody_o(instructionBody_o),
        .count_o(count_o),
        .overflow_o(overflow_o)
`ifdef DECODE_ISSUE_QUEUE_HWM_EN
        ,
        .highWater_o(highWater_o)
`endif
    );

    // Inputs change 1ns after the edge; outputs are sampled at the same point.
    task automatic tick;
        @(posedge clock_i);
        #1;
    endtask

    task automatic setMaj(input logic [63:0] maj);
        instMajId_i = maj;
        opcode_i    = maj[11:0] ^ 12'h5A5;
    endtask

    task automatic doReset;
        enable_i = 1'b0;
        stall_i  = 1'b1;
        reset_i  = 1'b0;
        tick();
        reset_i  = 1'b1;
    endtask

    task automatic test_reset;
        reset_i = 1'b0;
        enable_i = 1'b1;
        stall_i = 1'b0;
        setMaj(64'd99);
        tick();
        tick();
        checks++;
        if (count_o !== 4'd0) begin
            errors++; $display("FAIL reset_count got %0d expected 0", count_o);
        end
        checks++;
        if (enable_o !== 1'b0) begin
            errors++; $display("FAIL reset_enable got %b expected 0", enable_o);
        end
        checks++;
        if (overflow_o !== 1'b0 || stall_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags got ovf=%b stall=%b expected 0 0", overflow_o, stall_o);
        end
        checks++;
        if (opcode_o !== 12'd0 || instMajId_o !== 64'd0 || instructionBody_o !== 26'd0) begin
            errors++;
            $display("FAIL reset_fields got op=%h maj=%0d expected 0 0", opcode_o, instMajId_o);
        end
        reset_i = 1'b1;
        enable_i = 1'b0;
    endtask

    task automatic test_pass_through;
        stall_i = 1'b0;
        enable_i = 1'b1;
        opcode_i = 12'h0E0;
        instructionAddress_i = 64'h40;
        instMajId_i = 64'd5;
        functionalUnitType_i = 3'd6;
        instMinId_i = 7'h55;
        is64Bit_i = 1'b1;
        instPid_i = 20'hABCDE;
        instTid_i = 16'h1234;
        op1rw_i = 2'b10;
        op2rw_i = 2'b01;
        op1isReg_i = 1'b1;
        op2isReg_i = 1'b0;
        immIsExtended_i = 1'b1;
        immIsShifted_i = 1'b0;
        instructionBody_i = 26'h2345678;
        tick();
        enable_i = 1'b0;
        checks++;
        if (count_o !== 4'd1 || enable_o !== 1'b0) begin
            errors++;
            $display("FAIL pass_edgeN got cnt=%0d en=%b expected 1 0", count_o, enable_o);
        end
        tick();
        checks++;
        if (enable_o !== 1'b1 || count_o !== 4'd0) begin
            errors++;
            $display("FAIL pass_edgeN1 got en=%b cnt=%0d expected 1 0", enable_o, count_o);
        end
        checks++;
        if (opcode_o !== 12'h0E0 || instructionAddress_o !== 64'h40 ||
            instMajId_o !== 64'd5 || functionalUnitType_o !== 3'd6 ||
            instMinId_o !== 7'h55 || is64Bit_o !== 1'b1 ||
            instPid_o !== 20'hABCDE || instTid_o !== 16'h1234) begin
            errors++;
            $display("FAIL pass_fields_a got op=%h addr=%h maj=%0d expected 0e0 40 5",
                     opcode_o, instructionAddress_o, instMajId_o);
        end
        checks++;
        if (op1rw_o !== 2'b10 || op2rw_o !== 2'b01 || op1isReg_o !== 1'b1 ||
            op2isReg_o !== 1'b0 || immIsExtended_o !== 1'b1 ||
            immIsShifted_o !== 1'b0 || instructionBody_o !== 26'h2345678) begin
            errors++;
            $display("FAIL pass_fields_b got body=%h expected 2345678", instructionBody_o);
        end
        tick();
        checks++;
        if (enable_o !== 1'b0 || count_o !== 4'd0 || opcode_o !== 12'h0E0) begin
            errors++;
            $display("FAIL pass_edgeN2 got en=%b cnt=%0d op=%h expected 0 0 0e0",
                     enable_o, count_o, opcode_o);
        end
    endtask

    task automatic test_fill_stall;
        stall_i = 1'b1;
        for (int i = 0; i < 8; i++) begin
            setMaj(64'(i));
            enable_i = 1'b1;
            tick();
            checks++;
            if (count_o !== 4'(i + 1) || stall_o !== (i + 1 >= 6) || enable_o !== 1'b0) begin
                errors++;
                $display("FAIL fill_%0d got cnt=%0d stall=%b en=%b expected %0d %b 0",
                         i, count_o, stall_o, enable_o, i + 1, (i + 1 >= 6));
            end
        end
        enable_i = 1'b0;
    endtask

    task automatic test_overflow;
        setMaj(64'd8);
        enable_i = 1'b1;
        tick();
        enable_i = 1'b0;
        checks++;
        if (overflow_o !== 1'b1 || count_o !== 4'd8) begin
            errors++;
            $display("FAIL ovf_drop got ovf=%b cnt=%0d expected 1 8", overflow_o, count_o);
        end
        tick();
        stall_i = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            checks++;
            if (enable_o !== 1'b1 || instMajId_o !== 64'(i)) begin
                errors++;
                $display("FAIL ovf_drain_%0d got en=%b maj=%0d expected 1 %0d",
                         i, enable_o, instMajId_o, i);
            end
        end
        tick();
        checks++;
        if (enable_o !== 1'b0 || count_o !== 4'd0 || overflow_o !== 1'b1) begin
            errors++;
            $display("FAIL ovf_after got en=%b cnt=%0d ovf=%b expected 0 0 1",
                     enable_o, count_o, overflow_o);
        end
    endtask

    task automatic test_full_push_pop;
        logic [63:0] expMaj [8];
        doReset();
        for (int i = 0; i < 8; i++) begin
            setMaj(64'(10 + i));
            enable_i = 1'b1;
            tick();
        end
        stall_i = 1'b0;
        setMaj(64'd20);
        tick();
        enable_i = 1'b0;
        checks++;
        if (count_o !== 4'd8 || overflow_o !== 1'b0 || enable_o !== 1'b1 ||
            instMajId_o !== 64'd10) begin
            errors++;
            $display("FAIL full_pp got cnt=%0d ovf=%b en=%b maj=%0d expected 8 0 1 10",
                     count_o, overflow_o, enable_o, instMajId_o);
        end
        for (int i = 0; i < 7; i++) expMaj[i] = 64'(11 + i);
        expMaj[7] = 64'd20;
        for (int i = 0; i < 8; i++) begin
            tick();
            checks++;
            if (enable_o !== 1'b1 || instMajId_o !== expMaj[i]) begin
                errors++;
                $display("FAIL full_pp_drain_%0d got en=%b maj=%0d expected 1 %0d",
                         i, enable_o, instMajId_o, expMaj[i]);
            end
        end
        checks++;
        if (count_o !== 4'd0 || overflow_o !== 1'b0) begin
            errors++;
            $display("FAIL full_pp_end got cnt=%0d ovf=%b expected 0 0", count_o, overflow_o);
        end
    endtask

    task automatic test_mid_reset;
        doReset();
        for (int i = 0; i < 3; i++) begin
            setMaj(64'(30 + i));
            enable_i = 1'b1;
            tick();
        end
        reset_i = 1'b0;
        tick();
        checks++;
        if (count_o !== 4'd0 || enable_o !== 1'b0) begin
            errors++;
            $display("FAIL midrst got cnt=%0d en=%b expected 0 0", count_o, enable_o);
        end
        reset_i = 1'b1;
        enable_i = 1'b0;
        stall_i = 1'b0;
        tick();
        checks++;
        if (count_o !== 4'd0 || enable_o !== 1'b0) begin
            errors++;
            $display("FAIL midrst_after got cnt=%0d en=%b expected 0 0", count_o, enable_o);
        end
    endtask

    task automatic test_back_to_back;
        int inIdx = 0;
        int outIdx = 0;
        int cyc = 0;
        int maxCnt = 0;
        doReset();
        while (outIdx < 40 && cyc < 1000) begin
            stall_i = ((cyc / 3) % 2) == 1;
            if (inIdx < 40 && !stall_o) begin
                setMaj(64'(100 + inIdx));
                enable_i = 1'b1;
                inIdx++;
            end else begin
                enable_i = 1'b0;
            end
            tick();
            cyc++;
            if (int'(count_o) > maxCnt) maxCnt = int'(count_o);
            if (enable_o === 1'b1) begin
                checks++;
                if (instMajId_o !== 64'(100 + outIdx)) begin
                    errors++;
                    $display("FAIL wrap_order_%0d got maj=%0d expected %0d",
                             outIdx, instMajId_o, 100 + outIdx);
                end
                outIdx++;
            end
        end
        enable_i = 1'b0;
        checks++;
        if (outIdx != 40) begin
            errors++;
            $display("FAIL wrap_timeout got %0d records expected 40", outIdx);
        end
        checks++;
        if (overflow_o !== 1'b0) begin
            errors++;
            $display("FAIL wrap_overflow got %b expected 0", overflow_o);
        end
`ifdef DECODE_ISSUE_QUEUE_HWM_EN
        checks++;
        if (highWater_o !== 4'(maxCnt)) begin
            errors++;
            $display("FAIL wrap_hwm got %0d expected %0d", highWater_o, maxCnt);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_pass_through();
        test_fill_stall();
        test_overflow();
        test_full_push_pop();
        test_mid_reset();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/decode_issue_queue.md
Name: decode_issue_queue

Overview:
- Buffers decoded instructions produced by the format-specific decoders (D-format and siblings) before they reach dispatch.
- FIFO of fully decoded instruction records, written on the decoder's enable pulse and drained into a registered output stage.
- Generates back-pressure (`stall_o`) early enough to cover the decoder's one-cycle pipeline.

Parameters:
- addressWidth, 64, instruction address width
- opcodeSize, 12, decoded opcode width
- funcUnitCodeSize, 3, functional unit code width
- instructionCounterWidth, 64, major ID width
- instMinIdWidth, 7, minor ID width
- PidSize, 20, process ID width
- TidSize, 16, thread ID width
- regAccessPatternSize, 2, operand read/write flag width
- bodySize, 26, instruction body width (2 regs + 16-bit imm)
- queueDepth, 8, entries; power of two, >= 4
- stallMargin, 2, free entries reserved when `stall_o` asserts

Ports:
- clock_i in 1: clock, rising edge
- reset_i in 1: synchronous active-low reset
- enable_i in 1: decoded instruction valid (push request)
- opcode_i in opcodeSize
- instructionAddress_i in addressWidth
- functionalUnitType_i in funcUnitCodeSize
- instMajId_i in instructionCounterWidth
- instMinId_i in instMinIdWidth
- is64Bit_i in 1
- instPid_i in PidSize
- instTid_i in TidSize
- op1rw_i, op2rw_i in regAccessPatternSize each
- op1isReg_i, op2isReg_i, immIsExtended_i, immIsShifted_i in 1 each
- instructionBody_i in bodySize
- stall_i in 1: downstream not accepting
- stall_o out 1: to decoders, stop issuing
- enable_o out 1: output record valid, one-cycle pulse per instruction
- opcode_o … instructionBody_o out: same fields and widths as the inputs, `_o` suffix
- count_o out clog2(queueDepth)+1: current occupancy
- overflow_o out 1: sticky, a push was dropped

Behaviour:
- Reset (`reset_i`=0 at an edge): read/write pointers and count go to 0, `enable_o`=0, `overflow_o`=0, all record outputs 0, `stall_o`=0. Reset overrides any push or pop in the same cycle. Mid-operation reset discards all contents.
- Push: at an edge with `enable_i`=1 and count<queueDepth, write all input fields at the write pointer and increment the pointer (wraps modulo queueDepth).
- Push when full: `enable_i`=1 and count==queueDepth with no pop in the same cycle. Record is dropped, `overflow_o`<=1 and stays 1 until reset, count unchanged.
- Pop: at an edge with `stall_i`=0 and count>0:
  - head record loads into the output registers;
  - `enable_o`<=1 and the read pointer increments with wrap.
- No pop otherwise: `enable_o`<=0 and record outputs hold their last value.
- Simultaneous push and pop: both happen and count is unchanged. When full, the pop frees a slot, so the push is accepted with no overflow.
- Latency:
  - no bypass; a record pushed at edge N is popped no earlier than edge N+1;
  - `enable_o` is high after edge N+1;
  - an empty queue with continuous `stall_i`=0 gives a minimum 1-cycle latency and throughput of 1 per cycle.
- Ordering: strict FIFO; records are never reordered or modified.
- `stall_o`: combinational, = (count >= queueDepth - stallMargin).
- `count_o`: registered occupancy, range 0..queueDepth.

Optional Feature:
- Macro: `DECODE_ISSUE_QUEUE_HWM_EN`.
- Defined:
  - adds output `highWater_o` (clog2(queueDepth)+1 bits) = maximum count reached since reset, updated on the same edge as count;
  - reset value 0.
- Undefined: port absent; no extra logic. All other behaviour is identical in both builds.

Test Plan:
- Reset: hold `reset_i`=0 for 2 edges with `enable_i`=1 → `count_o`=0, `enable_o`=0, `overflow_o`=0, `stall_o`=0, all fields 0.
- Single pass-through: `stall_i`=0, push opcode 12'h0E0, addr 0x40, majId 5 at edge N → at edge N+1 `enable_o`=1 with identical fields; at edge N+2 `enable_o`=0, `count_o`=0.
- Fill and stall: `stall_i`=1, push majIds 0..7 on consecutive edges → `stall_o` rises when `count_o`=6; `count_o`=8; no `enable_o`.
- Overflow: from full with `stall_i`=1, push majId 8 → dropped, `overflow_o`=1 sticky, `count_o`=8. Release `stall_i` → majIds 0..7 emerge in order on 8 consecutive `enable_o` pulses; majId 8 never appears.
- Concurrent push/pop at full: `count_o`=8, `stall_i`=0, push majId 20 → `count_o` stays 8, no overflow, majId 20 emerges last after 8 pops.
- Wrap-around: 40 pushes with `stall_i` toggling every 3 cycles → all 40 majIds out in order; `overflow_o`=0. With `DECODE_ISSUE_QUEUE_HWM_EN` defined, `highWater_o` equals the maximum observed `count_o`.
